rgb_stream_distributor: RTL and testbench
=========================================

// Module: rgb_stream_distributor
// PURPOSE
//  Inverse of the one-hot RGB selector: steers one incoming RGB pixel stream to one, several,
//  or a round-robin-chosen output of NUM_PORTS pixel streams. All streams use valid/ready.
//  Each output has a one-entry register slot. Sits between a pixel source and parallel
//  pixel consumers.
// PARAMETERS
//  NUM_PORTS   4   number of output streams (2..8)
//  PIXEL_W     8   width of each colour channel r/g/b
// PORTS
//  clk        in   1                   clock, rising edge
//  rst_n      in   1                   asynchronous active-low reset
//  in_valid   in   1                   input pixel valid
//  in_ready   out  1                   input pixel accepted when in_valid & in_ready
//  in_r       in   PIXEL_W             input red
//  in_g       in   PIXEL_W             input green
//  in_b       in   PIXEL_W             input blue
//  in_sel     in   NUM_PORTS           destination mask: 0 = round-robin, 1 bit = unicast, >1 = broadcast
//  out_valid  out  NUM_PORTS           per-port pixel valid (bit i = port i)
//  out_ready  in   NUM_PORTS           per-port consumer ready
//  out_r      out  NUM_PORTS*PIXEL_W   per-port red; port i at [i*PIXEL_W +: PIXEL_W]
//  out_g      out  NUM_PORTS*PIXEL_W   per-port green, same packing
//  out_b      out  NUM_PORTS*PIXEL_W   per-port blue, same packing
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_valid=0, out_r/g/b=0, rr_ptr=0. in_ready is forced to 0
//    while rst_n=0.
//  - Per-port free[i] = ~out_valid[i] | out_ready[i]. A slot drained and refilled in the
//    same cycle holds the new pixel next cycle and stays valid.
//  - Unicast/broadcast (in_sel!=0): in_ready = AND of free[i] over all set bits of in_sel.
//    On accept, every selected slot loads {r,g,b} and sets out_valid. Broadcast is
//    all-or-nothing; no partial writes.
//  - Round-robin (in_sel==0): target = first i with free[i], scanning
//    rr_ptr, rr_ptr+1, ... mod NUM_PORTS. in_ready = OR of free.
//    On accept: the target slot loads the pixel and rr_ptr <= (target+1) mod NUM_PORTS.
//    rr_ptr is unchanged when no pixel is accepted and in unicast/broadcast modes.
//  - Slot not loaded and out_ready[i]=1: out_valid[i] <= 0. Data is held (not cleared) while
//    the slot is invalid.
//  - Data stays stable while out_valid[i]=1 and out_ready[i]=0 (AXI-style hold).
//  - Latency: pixel accepted in cycle N appears on out_* in cycle N+1. Throughput is 1 pixel
//    per cycle per port.
//  - in_ready depends combinationally on in_sel, in_valid-independent state and out_ready.
//    There is no combinational path from in_valid to in_ready.
//  - in_valid=0: no slot is loaded, regardless of in_sel.
//  - rr_ptr is log2(NUM_PORTS) bits. Wrap from NUM_PORTS-1 to 0 is explicit (non-power-of-2
//    safe).
//  - Reset mid-stream discards all slot contents. No pixel is emitted after rst_n rises until
//    a new accept.
// STRUCTURE
//  - Package rgb_pkg: PIXEL_W default and typedef rgb_t {r,g,b}. The top port list keeps
//    flattened _r/_g/_b.
//  - Sub-module rgb_out_slot: one-entry register slice with ports load, din, valid,
//    ready, dout, free. Instantiated NUM_PORTS times via generate.
//  - Top holds the target-mask decode (unicast/broadcast/round-robin priority scan) and
//    rr_ptr.
// TESTING
//  1. Reset: drive rst_n=0 mid-traffic -> out_valid=0, in_ready=0 immediately; rr_ptr=0
//     after release.
//  2. Unicast: sel=4'b0100, rgb=(0x12,0x34,0x56), all ready -> next cycle
//     out_valid=4'b0100, port2 data=0x12/0x34/0x56.
//  3. Broadcast backpressure: sel=4'b1010, port3 full with out_ready[3]=0 -> in_ready=0 and
//     port1 is not written. Raise out_ready[3] -> both ports load the same cycle.
//  4. Round-robin: sel=0, 6 back-to-back pixels, all ready -> ports 0,1,2,3,0,1 in order.
//     Block port1 (full, not ready) -> sequence skips port1.
//  5. Same-cycle drain+fill: port0 valid, out_ready[0]=1, new pixel to port0 -> out_valid[0]
//     stays 1 and data updates. 1 pixel/cycle is sustained for 16 cycles.
//  6. All full, none ready, sel=0 -> in_ready=0 and rr_ptr is unchanged.
//     Random out_ready soak: scoreboard checks no loss, no duplication, order per port.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB stream distributor.
package rgb_pkg;

    localparam int PIXEL_W_DEF   = 8;
    localparam int NUM_PORTS_DEF = 4;

    typedef struct packed {
        logic [PIXEL_W_DEF-1:0] r;
        logic [PIXEL_W_DEF-1:0] g;
        logic [PIXEL_W_DEF-1:0] b;
    } rgb_t;

    // Explicit wrap keeps the pointer correct for non-power-of-2 port counts.
    function automatic int wrap_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rgb_out_slot.sv
// One-entry output register slice: loads when told, drains on ready, reports free.
module rgb_out_slot #(
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] din,
    output logic          valid,
    input  logic          ready,
    output logic [DW-1:0] dout,
    output logic          free
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;

    // A drained slot that is refilled in the same cycle stays valid.
    assign valid_d = load | (valid_q & ~ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                data_q <= din;
            end
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;
    assign free  = ~valid_q | ready;

endmodule

// File: rtl/rgb_stream_distributor.sv
// Steers one RGB pixel stream to a unicast, broadcast or round-robin set of output slots.
module rgb_stream_distributor
    import rgb_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int PIXEL_W   = PIXEL_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PIXEL_W-1:0]           in_r,
    input  logic [PIXEL_W-1:0]           in_g,
    input  logic [PIXEL_W-1:0]           in_b,
    input  logic [NUM_PORTS-1:0]         in_sel,
    output logic [NUM_PORTS-1:0]         out_valid,
    input  logic [NUM_PORTS-1:0]         out_ready,
    output logic [NUM_PORTS*PIXEL_W-1:0] out_r,
    output logic [NUM_PORTS*PIXEL_W-1:0] out_g,
    output logic [NUM_PORTS*PIXEL_W-1:0] out_b
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int DW    = 3 * PIXEL_W;

    logic [NUM_PORTS-1:0] free;
    logic [NUM_PORTS-1:0] rr_mask;
    logic [NUM_PORTS-1:0] load_mask;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     rr_ptr_d;
    logic [PTR_W-1:0]     rr_target;
    logic                 rr_found;
    logic                 sel_rr;
    logic                 accept;
    logic [DW-1:0]        in_pix;
    logic [DW-1:0]        slot_dout [NUM_PORTS];

    assign sel_rr = (in_sel == '0);
    assign in_pix = {in_r, in_g, in_b};

    // First free port scanning upward from rr_ptr with wrap.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        rr_mask   = '0;
        rr_target = '0;
        rr_found  = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_PORTS)) begin
                sum = sum - (PTR_W+1)'(NUM_PORTS);
            end
            idx = sum[PTR_W-1:0];
            if (!rr_found && free[idx]) begin
                rr_found     = 1'b1;
                rr_target    = idx;
                rr_mask[idx] = 1'b1;
            end
        end
    end

    // in_ready never looks at in_valid.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            in_ready = sel_rr ? rr_found : &(free | ~in_sel);
        end
    end

    assign accept    = in_valid & in_ready;
    assign load_mask = accept ? (sel_rr ? rr_mask : in_sel) : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && sel_rr) begin
            rr_ptr_d = PTR_W'(wrap_next(int'(rr_target), NUM_PORTS));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
        rgb_out_slot #(
            .DW(DW)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load_mask[i]),
            .din   (in_pix),
            .valid (out_valid[i]),
            .ready (out_ready[i]),
            .dout  (slot_dout[i]),
            .free  (free[i])
        );

        assign out_r[i*PIXEL_W +: PIXEL_W] = slot_dout[i][2*PIXEL_W +: PIXEL_W];
        assign out_g[i*PIXEL_W +: PIXEL_W] = slot_dout[i][PIXEL_W +: PIXEL_W];
        assign out_b[i*PIXEL_W +: PIXEL_W] = slot_dout[i][0 +: PIXEL_W];
    end

endmodule

// File: tb/tb_rgb_stream_distributor.sv
// Self-checking bench: reference model + per-port scoreboard, directed vectors and a random soak.
module tb_rgb_stream_distributor;
    import rgb_pkg::*;

    localparam int N  = 4;
    localparam int PW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [PW-1:0]   in_r = '0, in_g = '0, in_b = '0;
    logic [N-1:0]    in_sel = '0;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready = '0;
    logic [N*PW-1:0] out_r, out_g, out_b;

    rgb_stream_distributor #(.NUM_PORTS(N), .PIXEL_W(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    rgb_t        m_data  [N];
    logic        m_valid [N];
    int          m_rr;
    logic [23:0] sbq [N][$];

    function automatic bit m_free(input int i);
        return !m_valid[i] || out_ready[i];
    endfunction

    function automatic bit m_in_ready();
        bit r;
        if (!rst_n) return 1'b0;
        if (in_sel == '0) begin
            r = 1'b0;
            for (int i = 0; i < N; i++) if (m_free(i)) r = 1'b1;
        end else begin
            r = 1'b1;
            for (int i = 0; i < N; i++) if (in_sel[i] && !m_free(i)) r = 1'b0;
        end
        return r;
    endfunction

    function automatic int m_rr_target();
        for (int k = 0; k < N; k++) begin
            if (m_free((m_rr + k) % N)) return (m_rr + k) % N;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_upd
        bit           acc;
        int           tgt;
        logic [N-1:0] dest;
        if (!rst_n) begin
            m_rr = 0;
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0;
                m_data[i]  = '0;
                sbq[i].delete();
            end
        end else begin
            acc  = in_valid && m_in_ready();
            dest = '0;
            if (acc) begin
                if (in_sel == '0) begin
                    tgt       = m_rr_target();
                    dest[tgt] = 1'b1;
                    m_rr      = (tgt + 1) % N;
                end else begin
                    dest = in_sel;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (dest[i]) begin
                    m_valid[i] = 1'b1;
                    m_data[i]  = '{r: in_r, g: in_g, b: in_b};
                    sbq[i].push_back({in_r, in_g, in_b});
                end else if (out_ready[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_in_ready()));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(m_valid[i]));
            chk($sformatf("out_rgb[%0d]", i),
                {8'h0, out_r[i*PW +: PW], out_g[i*PW +: PW], out_b[i*PW +: PW]},
                {8'h0, m_data[i]});
            if (rst_n && out_valid[i] && out_ready[i]) begin
                n_checks++;
                if (sbq[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_dup port %0d: got pixel %0h expected none", i,
                             {out_r[i*PW +: PW], out_g[i*PW +: PW], out_b[i*PW +: PW]});
                end else begin
                    if ({out_r[i*PW +: PW], out_g[i*PW +: PW], out_b[i*PW +: PW]} !== sbq[i][0]) begin
                        n_fail++;
                        $display("FAIL sb_order port %0d: got %0h expected %0h", i,
                                 {out_r[i*PW +: PW], out_g[i*PW +: PW], out_b[i*PW +: PW]}, sbq[i][0]);
                    end
                    void'(sbq[i].pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [N-1:0] sel, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b, input logic [N-1:0] rdy);
        in_valid  = v;
        in_sel    = sel;
        in_r      = r;
        in_g      = g;
        in_b      = b;
        out_ready = rdy;
    endtask

    task automatic chk_port(input string nm, input int p, input logic [23:0] exp);
        chk(nm, {8'h0, out_r[p*PW +: PW], out_g[p*PW +: PW], out_b[p*PW +: PW]}, {8'h0, exp});
    endtask

    logic [N-1:0] rr_exp  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [N-1:0] blk_exp [4] = '{4'b0110, 4'b1010, 4'b0011, 4'b0110};
    int           blk_prt [4] = '{2, 3, 0, 2};

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Fill all slots, then reset mid-stream.
        for (int j = 0; j < 4; j++) begin
            drive(1, '0, 8'(j), 8'(j), 8'(j), 4'b0000);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        tick();
        drive(0, '0, 8'h0, 8'h0, 8'h0, 4'b1111);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(out_valid), 32'h0);

        // Round-robin from a freshly reset pointer.
        for (int j = 0; j < 6; j++) begin
            drive(1, '0, 8'(8'h10 + j), 8'(8'h20 + j), 8'(8'h30 + j), 4'b1111);
            tick();
            chk($sformatf("rr_seq%0d", j), 32'(out_valid), 32'(rr_exp[j]));
        end
        chk_port("rr_p1_data", 1, 24'h152535);

        // Port 1 held full, round-robin must skip it.
        drive(1, 4'b0010, 8'hEE, 8'hEE, 8'hEE, 4'b1101);
        tick();
        for (int j = 0; j < 4; j++) begin
            drive(1, '0, 8'(8'h40 + j), 8'h41, 8'h42, 4'b1101);
            tick();
            chk($sformatf("rr_skip%0d", j), 32'(out_valid), 32'(blk_exp[j]));
            chk_port($sformatf("rr_skip_data%0d", j), blk_prt[j], {8'(8'h40 + j), 8'h41, 8'h42});
        end
        drive(0, '0, 8'h0, 8'h0, 8'h0, 4'b1111);
        tick();

        // Unicast.
        drive(1, 4'b0100, 8'h12, 8'h34, 8'h56, 4'b1111);
        tick();
        chk("uni_valid", 32'(out_valid), 32'h4);
        chk_port("uni_p2_data", 2, 24'h123456);
        drive(0, 4'b0100, 8'h0, 8'h0, 8'h0, 4'b1111);
        tick();
        chk("uni_drained", 32'(out_valid), 32'h0);

        // Broadcast back-pressure.
        drive(1, 4'b1000, 8'h77, 8'h77, 8'h77, 4'b0000);
        tick();
        chk("bc_fill_p3", 32'(out_valid), 32'h8);
        drive(1, 4'b1010, 8'hA1, 8'hB2, 8'hC3, 4'b0000);
        #1;
        chk("bc_blocked_ready", 32'(in_ready), 32'h0);
        tick();
        chk("bc_no_partial", 32'(out_valid), 32'h8);
        chk_port("bc_p3_held", 3, 24'h777777);
        out_ready = 4'b1000;
        #1;
        chk("bc_unblocked_ready", 32'(in_ready), 32'h1);
        tick();
        chk("bc_both_valid", 32'(out_valid), 32'hA);
        chk_port("bc_p1_data", 1, 24'hA1B2C3);
        chk_port("bc_p3_data", 3, 24'hA1B2C3);
        drive(0, '0, 8'h0, 8'h0, 8'h0, 4'b1111);
        tick();

        // Same-cycle drain and refill on port 0, sustained.
        for (int j = 0; j < 16; j++) begin
            drive(1, 4'b0001, 8'(j * 3), 8'(j * 5 + 1), 8'(~j), 4'b1111);
            #1;
            chk("stream_ready", 32'(in_ready), 32'h1);
            tick();
            chk("stream_valid", 32'(out_valid), 32'h1);
            chk_port("stream_data", 0, {8'(j * 3), 8'(j * 5 + 1), 8'(~j)});
        end
        drive(0, '0, 8'h0, 8'h0, 8'h0, 4'b1111);
        tick();

        // All full, none ready: round-robin stalls and the pointer (3) is kept.
        drive(1, 4'b1111, 8'h5A, 8'h5A, 8'h5A, 4'b1111);
        tick();
        drive(1, '0, 8'h66, 8'h66, 8'h66, 4'b0000);
        #1;
        chk("full_in_ready", 32'(in_ready), 32'h0);
        for (int j = 0; j < 3; j++) tick();
        chk("full_valid", 32'(out_valid), 32'hF);
        chk_port("full_p0_held", 0, 24'h5A5A5A);
        drive(1, '0, 8'h11, 8'h22, 8'h33, 4'b1111);
        tick();
        chk("rr_ptr_kept", 32'(out_valid), 32'h8);
        chk_port("rr_ptr_kept_data", 3, 24'h112233);

        // Random soak.
        for (int j = 0; j < 400; j++) begin
            logic [N-1:0] sel;
            case ($urandom % 3)
                0:       sel = '0;
                1:       sel = 4'(1 << ($urandom % N));
                default: sel = 4'($urandom % 16);
            endcase
            drive(($urandom % 4) != 0, sel, 8'($urandom), 8'($urandom), 8'($urandom),
                  4'($urandom % 16));
            tick();
        end
        drive(0, '0, 8'h0, 8'h0, 8'h0, 4'b1111);
        tick();
        tick();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("sb_empty[%0d]", i), 32'(sbq[i].size()), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
